// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//
// Result write-back stage that sits directly after the 32-bit ALU. Each
// accepted ALU issue is held for one cycle in a pending register. On the
// following edge the registered ALU result z is aligned with it, the
// architectural HI/LO registers are updated, and the produced words go into
// a small circular FIFO. The FIFO drains onto the datapath bus through a
// valid/ready handshake.
//
// Opcode classes:
//   single-word (push LO)         : add sub and or neg not shl shr rol ror
//   double-word (push LO then HI) : mul div
//   everything else               : no push, HI/LO unchanged
//
// Ports:
//   clk        in   rising-edge clock, shared with the ALU
//   clr_n      in   asynchronous active-low reset
//   issue      in   ALU operation launched this cycle with select
//   select     in   ALU opcode (4 bits)
//   z          in   ALU result {HI,LO}, valid the cycle after issue
//   busy       out  issue not accepted this cycle
//   hi_q       out  architectural HI
//   lo_q       out  architectural LO
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer accepts head
//   out_data   out  FIFO head word (0 while empty)
//   out_hi     out  head word came from HI (0 = LO)
//   count      out  FIFO occupancy (AW+1 bits)
//   ovf        out  sticky: issue attempted while busy
//   out_par    out  even parity of out_data (ALU_WB_PARITY_EN only)
//
// Configuration macro:
//   ALU_WB_PARITY_EN - adds out_par. Parity is computed at push time and
//                      stored with each FIFO entry (34-bit entries instead
//                      of 33-bit entries).
// ---------------------------------------------------------------------------
module alu_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          issue,
    input  logic [3:0]    select,
    input  logic [63:0]   z,
    output logic          busy,
    output logic [31:0]   hi_q,
    output logic [31:0]   lo_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_hi,
    output logic [AW:0]   count,
    output logic          ovf
`ifdef ALU_WB_PARITY_EN
    ,
    output logic          out_par
`endif
);

`ifdef ALU_WB_PARITY_EN
    localparam int unsigned FW = 34;
`else
    localparam int unsigned FW = 33;
`endif

    // Accept only while at least two slots stay free after the words already
    // owed to the pending op, so whatever is accepted is guaranteed to fit.
    localparam logic [AW+1:0] BUSY_LIMIT = (AW+2)'(DEPTH - 2);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    // Number of FIFO words an opcode produces.
    function automatic logic [1:0] words_of(input logic [3:0] op);
        logic [1:0] n;
        case (op)
            4'b0011, 4'b0101:                                  n = 2'd2;
            4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
            4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111:       n = 2'd1;
            default:                                           n = 2'd0;
        endcase
        return n;
    endfunction

    // FIFO entry layout: {[parity,] hi_flag, data}.
    function automatic logic [FW-1:0] make_entry(input logic hi_flag,
                                                 input logic [31:0] data);
`ifdef ALU_WB_PARITY_EN
        return {^data, hi_flag, data};
`else
        return {hi_flag, data};
`endif
    endfunction

    logic                r_pend_v;
    logic [3:0]          r_pend_sel;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                r_ovf;
    logic [FW-1:0]       r_mem [DEPTH];

    logic [1:0]          w_pend_words;
    logic [AW+1:0]       w_used;
    logic                w_busy;
    logic                w_accept;
    logic                w_valid;
    logic                w_pop;
    logic [AW-1:0]       w_wr_ptr_nxt;
    logic [AW:0]         w_count_d;
    logic [FW-1:0]       w_head;

    assign w_pend_words = r_pend_v ? words_of(r_pend_sel) : 2'd0;
    assign w_used       = {1'b0, r_count} + {{AW{1'b0}}, w_pend_words};
    assign w_busy       = (w_used > BUSY_LIMIT);
    assign w_accept     = issue & ~w_busy;
    assign w_valid      = (r_count != '0);
    // Pop only a head that was already visible; a word pushed this cycle
    // becomes poppable next cycle.
    assign w_pop        = w_valid & out_ready;
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    assign w_count_d    = r_count + (AW+1)'(w_pend_words) - (AW+1)'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];

    // Storage array carries no reset; stale entries are never exposed
    // because the head is gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_pend_words != 2'd0) begin
            r_mem[r_wr_ptr] <= make_entry(1'b0, z[31:0]);
        end
        if (w_pend_words == 2'd2) begin
            r_mem[w_wr_ptr_nxt] <= make_entry(1'b1, z[63:32]);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pend_v   <= 1'b0;
            r_pend_sel <= 4'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_pend_v   <= w_accept;
            r_pend_sel <= select;
            if (w_pend_words != 2'd0) begin
                r_lo <= z[31:0];
            end
            if (w_pend_words == 2'd2) begin
                r_hi <= z[63:32];
            end
            // Pointer wraps naturally since DEPTH is a power of two.
            r_wr_ptr <= r_wr_ptr + AW'(w_pend_words);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_d;
            if (issue && w_busy) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign busy      = w_busy;
    assign hi_q      = r_hi;
    assign lo_q      = r_lo;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_head[31:0] : 32'd0;
    assign out_hi    = w_valid ? w_head[32]   : 1'b0;
`ifdef ALU_WB_PARITY_EN
    assign out_par   = w_valid ? w_head[33]   : 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
//
// Self-checking bench for alu_writeback. A queue-based reference model
// predicts HI/LO, FIFO contents, busy and ovf from the opcode-class rules;
// every cycle the DUT outputs are compared with it, and directed scenarios
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_writeback;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          issue;
    logic [3:0]    select;
    logic [63:0]   z;
    logic          out_ready;
    logic          busy;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_hi;
    logic [AW:0]   count;
    logic          ovf;
`ifdef ALU_WB_PARITY_EN
    logic          out_par;
`endif

    alu_writeback #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .issue     (issue),
        .select    (select),
        .z         (z),
        .busy      (busy),
        .hi_q      (hi_q),
        .lo_q      (lo_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hi    (out_hi),
        .count     (count),
        .ovf       (ovf)
`ifdef ALU_WB_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        hi;
        logic [31:0] data;
    } word_t;

    word_t       m_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    bit          m_pend_v;
    logic [3:0]  m_pend_sel;
    bit          m_ovf;
    int          m_pushed;
    int          m_popped;

    function automatic int words_of(input logic [3:0] op);
        case (op)
            4'd3, 4'd5:                                         return 2;
            4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd12, 4'd13,
            4'd14, 4'd15:                                       return 1;
            default:                                            return 0;
        endcase
    endfunction

    function automatic bit m_busy();
        int res;
        res = m_pend_v ? words_of(m_pend_sel) : 0;
        return (DEPTH - m_q.size() - res) < 2;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hi = 0;
        m_lo = 0;
        m_pend_v = 0;
        m_pend_sel = 0;
        m_ovf = 0;
    endtask

    // Applies one rising edge worth of behaviour using the pre-edge inputs.
    task automatic model_step();
        bit b;
        int w;
        b = m_busy();
        if (m_q.size() != 0 && out_ready) begin
            void'(m_q.pop_front());
            m_popped++;
        end
        if (m_pend_v) begin
            w = words_of(m_pend_sel);
            if (w >= 1) begin
                m_lo = z[31:0];
                m_q.push_back({1'b0, z[31:0]});
                m_pushed++;
            end
            if (w == 2) begin
                m_hi = z[63:32];
                m_q.push_back({1'b1, z[63:32]});
                m_pushed++;
            end
        end
        if (issue && b) m_ovf = 1;
        m_pend_v   = issue && !b;
        m_pend_sel = select;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("busy", busy, m_busy());
        check("hi_q", hi_q, m_hi);
        check("lo_q", lo_q, m_lo);
        check("count", count, m_q.size());
        check("out_valid", out_valid, m_q.size() != 0);
        check("ovf", ovf, m_ovf);
        if (m_q.size() != 0) begin
            check("out_data", out_data, m_q[0].data);
            check("out_hi", out_hi, m_q[0].hi);
`ifdef ALU_WB_PARITY_EN
            check("out_par", out_par, ^m_q[0].data);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    logic [31:0] saved_lo;
    logic [31:0] saved_hi;
    int          guard;

    initial begin
        clr_n = 1'b0;
        issue = 1'b0;
        select = 4'd0;
        z = 64'd0;
        out_ready = 1'b0;
        m_pushed = 0;
        m_popped = 0;
        model_reset();

        // Reset state
        #12;
        compare_all();
        check("rst_count", count, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Single-word add, consumer ready
        issue = 1'b1; select = 4'b0001; out_ready = 1'b1;
        tick();
        issue = 1'b0; z = 64'h0000_0000_0000_0007;
        tick();
        check("t1_lo", lo_q, 32'd7);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'd7);
        check("t1_hi_flag", out_hi, 0);
        tick();
        check("t1_count_empty", count, 0);
        check("t1_hi", hi_q, 0);

        // Double-word mul with consumer stalled, then drained
        out_ready = 1'b0; issue = 1'b1; select = 4'b0011;
        tick();
        issue = 1'b0; z = 64'h0000_0001_FFFF_FFFE;
        tick();
        check("t2_hi", hi_q, 32'h1);
        check("t2_lo", lo_q, 32'hFFFF_FFFE);
        check("t2_count", count, 2);
        check("t2_head", out_data, 32'hFFFF_FFFE);
        check("t2_head_hi", out_hi, 0);
        z = {$urandom, $urandom};
        tick();
        check("t2_head_hold", out_data, 32'hFFFF_FFFE);
        out_ready = 1'b1;
        tick();
        check("t2_second", out_data, 32'h1);
        check("t2_second_hi", out_hi, 1);
        check("t2_count1", count, 1);
        tick();
        check("t2_empty", out_valid, 0);

        // Back-to-back adds with consumer stalled, then over-issue
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue = 1'b1; select = 4'b0001; z = {$urandom, $urandom};
            tick();
            if (i == 2) check("t3_busy_after3", busy, 1);
        end
        issue = 1'b0;
        tick();
        check("t3_ovf", ovf, 1);
        check("t3_count", count, 3);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t3_drained", count, 0);

        // Two muls fill the FIFO to DEPTH
        out_ready = 1'b0; issue = 1'b1; select = 4'b0011;
        z = {$urandom, $urandom};
        tick();
        z = {$urandom, $urandom};
        tick();
        issue = 1'b0; z = {$urandom, $urandom};
        tick();
        tick();
        check("t3_full", count, DEPTH);
        check("t3_full_busy", busy, 1);
        out_ready = 1'b1;
        repeat (5) tick();

        // No-op opcode: nothing pushed, HI/LO untouched
        saved_lo = m_lo; saved_hi = m_hi;
        issue = 1'b1; select = 4'b0100; z = {$urandom, $urandom};
        tick();
        check("t4_busy", busy, 0);
        issue = 1'b0; z = {$urandom, $urandom};
        tick();
        check("t4_count", count, 0);
        check("t4_lo", lo_q, saved_lo);
        check("t4_hi", hi_q, saved_hi);

        // Alternating add/div with continuous pop across pointer wrap
        m_pushed = 0; m_popped = 0; guard = 0;
        out_ready = 1'b1;
        for (int k = 0; m_pushed < 3 * DEPTH && guard < 200; guard++) begin
            z = {$urandom, $urandom};
            issue = !m_busy();
            select = k[0] ? 4'b0101 : 4'b0001;
            if (issue) k++;
            tick();
        end
        issue = 1'b0;
        repeat (6) tick();
        check("t5_budget", guard < 200, 1);
        check("t5_conserved", m_popped, m_pushed);
        check("t5_empty", count, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            issue = 1'($urandom_range(0, 1));
            select = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            z = {$urandom, $urandom};
            tick();
        end
        issue = 1'b0; out_ready = 1'b1;
        repeat (8) tick();

        // Asynchronous reset with a div pending and two words queued
        out_ready = 1'b0; issue = 1'b1; select = 4'b0011;
        z = {$urandom, $urandom};
        tick();
        select = 4'b0101; z = {$urandom, $urandom};
        tick();
        issue = 1'b0; z = 64'hDEAD_BEEF_1234_5678;
        check("t6_pre_count", count, 2);
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        check("t6_valid", out_valid, 0);
        check("t6_count", count, 0);
        check("t6_hi", hi_q, 0);
        check("t6_lo", lo_q, 0);
        check("t6_data", out_data, 0);
        check("t6_out_hi", out_hi, 0);
        check("t6_ovf", ovf, 0);
        check("t6_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        clr_n = 1'b1; out_ready = 1'b1;
        repeat (4) tick();
        check("t6_no_stale", out_valid, 0);
        check("t6_hi_after", hi_q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
